blink_tick_gen: RTL and testbench

Upstream timing stage for the Blinking-LED core. It divides the system clock into a base tick, then generates one single-cycle blink_en strobe per LED channel at a per-channel programmable period. Each led_blink instance toggles its LED on its blink_en bit. Channel periods are written at runtime through a simple write/ack config port.

---
 rtl/blink_tick_gen.sv | 101 ++++++++++
 tb/tb_blink_tick_gen.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/blink_tick_gen.sv
// Base-tick prescaler plus per-channel programmable blink strobe generators.
// Define BLINK_SIM_FAST_EN to force a prescale of 1 for short simulations.
module blink_tick_gen #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 1000,
  parameter int NUM_CH     = 4,
  parameter int RATE_W     = 10,
  parameter int PERIOD_RST = 500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sync,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_ch,
  input  logic [RATE_W-1:0] cfg_period,
  output logic              cfg_ack,
  output logic              cfg_err,
  output logic              base_tick,
  output logic [NUM_CH-1:0] blink_en
);

`ifdef BLINK_SIM_FAST_EN
  localparam int PRESCALE = 1;
`else
  localparam int PRESCALE = CLK_HZ / TICK_HZ;
`endif
  localparam int              PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [3:0]       NUM_CH_L = 4'(NUM_CH);

  if ((CLK_HZ / TICK_HZ) < 1 || (CLK_HZ % TICK_HZ) != 0) begin : g_bad_rate
    $error("blink_tick_gen: CLK_HZ must be a nonzero multiple of TICK_HZ");
  end
  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_ch
    $error("blink_tick_gen: NUM_CH must be 1..8");
  end

  logic [PRE_W-1:0] pre_cnt;
  logic             tick_s;

  assign tick_s = en & ~sync & (pre_cnt == PRE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (sync) begin
      pre_cnt <= '0;
    end else if (en) begin
      pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_tick <= 1'b0;
      cfg_ack   <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      base_tick <= tick_s;
      cfg_ack   <= cfg_we;
      cfg_err   <= cfg_we & ({1'b0, cfg_ch} >= NUM_CH_L);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [RATE_W-1:0] period;
    logic [RATE_W-1:0] cnt;
    logic              strobe;
    logic              wr_hit;

    assign wr_hit      = cfg_we && (cfg_ch == 3'(c));
    assign blink_en[c] = strobe;

    // A write landing together with sync still takes its new period, so an
    // acknowledged write is never lost; sync only overrides the counter.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        period <= RATE_W'(PERIOD_RST);
        cnt    <= '0;
        strobe <= 1'b0;
      end else begin
        strobe <= 1'b0;
        if (wr_hit) period <= cfg_period;
        if (sync) begin
          cnt <= '0;
        end else if (wr_hit) begin
          cnt <= '0;
        end else if (tick_s && (period != '0)) begin
          if (cnt == period - RATE_W'(1)) begin
            cnt    <= '0;
            strobe <= 1'b1;
          end else begin
            cnt <= cnt + RATE_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_blink_tick_gen.sv
// Scoreboard bench for blink_tick_gen: expected output events are queued with
// their edge number; a negedge monitor pops one per active output cycle.
module tb_blink_tick_gen;
  localparam int NUM_CH = 4;
  localparam int RATE_W = 10;
  localparam int EW     = 16 + 3 + NUM_CH;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b1;
  logic              sync = 1'b0;
  logic              cfg_we = 1'b0;
  logic [2:0]        cfg_ch = 3'd0;
  logic [RATE_W-1:0] cfg_period = '0;
  logic              cfg_ack;
  logic              cfg_err;
  logic              base_tick;
  logic [NUM_CH-1:0] blink_en;

  logic [EW-1:0] exp_q[$];
  logic [15:0]   cyc;
  int            n_chk  = 0;
  int            n_pass = 0;

  // Handshake: cfg_we is a one-cycle strobe; cfg_ack/cfg_err answer it on the
  // following cycle with no backpressure. base_tick/blink_en are pure strobes.
  blink_tick_gen #(
    .CLK_HZ(10), .TICK_HZ(1), .NUM_CH(NUM_CH), .RATE_W(RATE_W), .PERIOD_RST(3)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
    .cfg_ack(cfg_ack), .cfg_err(cfg_err),
    .base_tick(base_tick), .blink_en(blink_en)
  );

  // clock / reset-relative edge counter
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= '0;
    else     cyc <= cyc + 16'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic wait_neg(input int n);
    do @(negedge clk); while (int'(cyc) != n);
  endtask

  task automatic cfg_write(input logic [2:0] ch, input logic [RATE_W-1:0] p);
    cfg_we     = 1'b1;
    cfg_ch     = ch;
    cfg_period = p;
  endtask

  task automatic push(input int c, input bit ack, input bit err, input bit bt,
                      input logic [NUM_CH-1:0] be);
    exp_q.push_back({16'(c), ack, err, bt, be});
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, req);
  endtask

  task automatic push_startup();
    push(10, 0, 0, 1, 4'b0000);
    push(20, 0, 0, 1, 4'b0000);
    push(30, 0, 0, 1, 4'b1111);
    push(40, 0, 0, 1, 4'b0000);
    push(50, 0, 0, 1, 4'b0000);
    push(60, 0, 0, 1, 4'b1111);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [EW-1:0] obs;
    logic [EW-1:0] req;
    if (!rst && (cfg_ack || cfg_err || base_tick || (|blink_en))) begin
      obs = {cyc, cfg_ack, cfg_err, base_tick, blink_en};
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL event: unexpected cyc=%0d ack=%b err=%b bt=%b blink=%b",
                 cyc, cfg_ack, cfg_err, base_tick, blink_en);
      end else begin
        req = exp_q.pop_front();
        if (obs === req) n_pass++;
        else $display("FAIL event: got cyc=%0d ack/err/bt=%b blink=%b, expected cyc=%0d ack/err/bt=%b blink=%b",
                      obs[EW-1 -: 16], obs[NUM_CH+2 -: 3], obs[NUM_CH-1:0],
                      req[EW-1 -: 16], req[NUM_CH+2 -: 3], req[NUM_CH-1:0]);
      end
    end
  end

  initial begin
    logic [EW-1:0] left;
    // startup, writes, disable/error, collision, pause/resume, sync
    push_startup();
    push(61, 1, 0, 0, 4'b0000);
    push(70, 0, 0, 1, 4'b0010);
    push(80, 0, 0, 1, 4'b0010);
    push(90, 0, 0, 1, 4'b1111);
    push(91, 1, 0, 0, 4'b0000);
    push(92, 1, 1, 0, 4'b0000);
    for (int k = 0; k < 11; k++)
      push(100 + 10 * k, 0, 0, 1, (k % 3 == 2) ? 4'b1011 : 4'b0010);
    push(210, 1, 0, 1, 4'b1010);
    push(220, 0, 0, 1, 4'b0010);
    push(230, 0, 0, 1, 4'b0011);
    push(240, 0, 0, 1, 4'b1010);
    push(275, 0, 0, 1, 4'b0011);
    push(285, 0, 0, 1, 4'b0010);
    push(295, 0, 0, 1, 4'b1011);
    push(310, 0, 0, 1, 4'b0010);
    push(320, 0, 0, 1, 4'b0011);
    push(330, 0, 0, 1, 4'b1010);
    push_startup();

    #23;
    check1("rst_base_tick", base_tick, 1'b0);
    check1("rst_blink_en", |blink_en, 1'b0);
    check1("rst_cfg_ack", cfg_ack | cfg_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    wait_neg(60);  cfg_write(3'd1, 10'd1);
    wait_neg(61);  cfg_we = 1'b0;
    wait_neg(90);  cfg_write(3'd2, 10'd0);
    wait_neg(91);  cfg_write(3'd5, 10'd7);
    wait_neg(92);  cfg_we = 1'b0;
    wait_neg(209); cfg_write(3'd0, 10'd2);
    wait_neg(210); cfg_we = 1'b0;
    wait_neg(244); en = 1'b0;
    wait_neg(269); en = 1'b1;
    wait_neg(299); sync = 1'b1;
    wait_neg(300); sync = 1'b0;

    // async reset mid-period, right after a strobe cycle begins
    wait_neg(339);
    @(posedge clk);
    #1;
    check1("pre_rst_base_tick", base_tick, 1'b1);
    rst = 1'b1;
    #1;
    check1("async_rst_base_tick", base_tick, 1'b0);
    check1("async_rst_blink_en", |blink_en, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_neg(65);

    while (exp_q.size() != 0) begin
      left = exp_q.pop_front();
      n_chk++;
      $display("FAIL event: missing expected cyc=%0d ack/err/bt=%b blink=%b",
               left[EW-1 -: 16], left[NUM_CH+2 -: 3], left[NUM_CH-1:0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
